// File: rtl/reaction_timer.sv
// reaction_timer
//   Reaction-measurement phase of the reaction game. A rising edge on
//   countdown_done arms a round: after a pseudo-random hold-off the GO LED
//   lights, then elapsed milliseconds are counted in BCD until the player
//   presses the button. A press before GO is a false start. No press within
//   9999 ms is a timeout.
//
// Parameters
//   TICK_DIV     clk cycles per 1 ms tick
//   RAND_MIN_MS  minimum hold-off before GO, in ms
//   LFSR_SEED    non-zero reset value of the 16-bit LFSR
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   countdown_done level from the countdown stage; its rising edge arms a round
//   btn            debounced, synchronised button level (high = pressed)
//   go_led         high while waiting for the player's response
//   result_bcd     {thousands, hundreds, tens, ones} ms, BCD
//   result_valid   high while result_bcd holds a finished measurement
//   false_start    button pressed before GO
//   timeout        no press before 9999 ms
//   busy           round in progress (WAIT_RAND or MEASURE)
//   best_bcd       best (lowest) valid result
//
// Build option
//   REACTION_BEST_SCORE_EN  when defined, best_bcd tracks the lowest valid,
//                           non-timeout result. Otherwise it is tied to 9999.
module reaction_timer #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned RAND_MIN_MS = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        countdown_done,
    input  logic        btn,
    output logic        go_led,
    output logic [15:0] result_bcd,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic        busy,
    output logic [15:0] best_bcd
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_RAND = 2'd1;
    localparam logic [1:0] S_MEASURE   = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    // Wide enough for RAND_MIN_MS + 1023.
    localparam int DELAY_W = $clog2(RAND_MIN_MS + 1024);

    logic [1:0]         state_q, state_d;
    logic               done_q, btn_q;
    logic [15:0]        lfsr_q;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        result_q, result_d;
    logic               valid_q, valid_d;
    logic               fs_q, fs_d;
    logic               to_q, to_d;
    logic               go_q;
    logic               arm, press, tick, lfsr_fb;

    // Increment a 4-digit BCD value, each digit carrying 9 -> 0.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign arm     = countdown_done & ~done_q;
    // A level already high when sampled is not a press; only a fresh edge is.
    assign press   = btn & ~btn_q;
    assign tick    = (tick_q == TICK_LAST);
    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        delay_d  = delay_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = valid_q;
        fs_d     = fs_q;
        to_d     = to_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // arm while busy never reaches here, so a round cannot restart.
                if (arm) begin
                    state_d  = S_WAIT_RAND;
                    delay_d  = DELAY_W'(RAND_MIN_MS) + DELAY_W'(lfsr_q[9:0]);
                    count_d  = 16'h0000;
                    result_d = 16'h0000;
                    valid_d  = 1'b0;
                    fs_d     = 1'b0;
                    to_d     = 1'b0;
                end
            end
            S_WAIT_RAND: begin
                // Press wins over the hold-off expiring in the same cycle.
                if (press) begin
                    state_d  = S_DONE;
                    fs_d     = 1'b1;
                    result_d = 16'h0000;
                end else if (tick) begin
                    if (delay_q <= DELAY_W'(1)) begin
                        state_d = S_MEASURE;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
            end
            S_MEASURE: begin
                // Press wins over a tick: the count shown is the one latched.
                if (press) begin
                    state_d  = S_DONE;
                    result_d = count_q;
                    valid_d  = 1'b1;
                end else if (tick) begin
                    if (count_q == 16'h9998) begin
                        state_d  = S_DONE;
                        count_d  = 16'h9999;
                        result_d = 16'h9999;
                        valid_d  = 1'b1;
                        to_d     = 1'b1;
                    end else begin
                        count_d = bcd_inc(count_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restart the ms divider on every state entry so the first tick
        // lands a full TICK_DIV cycles after the transition.
        if (state_d != state_q || tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            btn_q    <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            tick_q   <= '0;
            delay_q  <= '0;
            count_q  <= 16'h0000;
            result_q <= 16'h0000;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            to_q     <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            done_q   <= countdown_done;
            btn_q    <= btn;
            lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
            tick_q   <= tick_d;
            delay_q  <= delay_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            to_q     <= to_d;
            go_q     <= (state_q == S_MEASURE);
        end
    end

    assign go_led       = go_q;
    assign result_bcd   = result_q;
    assign result_valid = valid_q;
    assign false_start  = fs_q;
    assign timeout      = to_q;
    assign busy         = (state_q == S_WAIT_RAND) || (state_q == S_MEASURE);

`ifdef REACTION_BEST_SCORE_EN
    logic [15:0] best_q;

    // Digit-wise BCD compare, most significant digit decides first.
    function automatic logic bcd_less(input logic [15:0] a, input logic [15:0] b);
        logic lt;
        logic decided;
        lt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                lt      = (a[4*i +: 4] < b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return lt;
    endfunction

    // Only a real measurement (press in MEASURE) can improve the best score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= 16'h9999;
        end else if (state_q == S_MEASURE && state_d == S_DONE && valid_d && !to_d
                     && bcd_less(result_d, best_q)) begin
            best_q <= result_d;
        end
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = 16'h9999;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer
//   Directed bench for reaction_timer with TICK_DIV=4, RAND_MIN_MS=2,
//   LFSR_SEED=16'h0001. Expected round outcomes are queued when the stimulus
//   is driven and popped when the round ends.
module tb_reaction_timer;

    localparam int TICK = 4;
    localparam int RMIN = 2;

`ifdef REACTION_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        countdown_done;
    logic        btn;
    logic        go_led;
    logic [15:0] result_bcd;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic        busy;
    logic [15:0] best_bcd;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [15:0] result;
        logic        valid;
        logic        fs;
        logic        to;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] lfsr_m;
    logic [15:0] best_m;

    reaction_timer #(
        .TICK_DIV   (TICK),
        .RAND_MIN_MS(RMIN),
        .LFSR_SEED  (16'h0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .countdown_done(countdown_done),
        .btn           (btn),
        .go_led        (go_led),
        .result_bcd    (result_bcd),
        .result_valid  (result_valid),
        .false_start   (false_start),
        .timeout       (timeout),
        .busy          (busy),
        .best_bcd      (best_bcd)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, advancing every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'h0001;
        else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_go_led"},       go_led,       0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_result"},       result_bcd,   16'h0000);
        check({tag, "_valid"},        result_valid, 0);
        check({tag, "_false_start"},  false_start,  0);
        check({tag, "_timeout"},      timeout,      0);
        check({tag, "_best"},         best_bcd,     16'h9999);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        bit active = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy !== 1'b0 || go_led !== 1'b0) active = 1'b1;
        end
        check({tag, "_stays_idle"}, active, 0);
    endtask

    // Arms a round; returns at the negedge just after the arming clock edge.
    task automatic arm_round(input bit want_three, output int exp_delay);
        int waited = 0;
        @(negedge clk);
        // Pick an arming moment with a short hold-off to keep the run short.
        while (waited < 3000 &&
               (want_three ? (lfsr_m[9:0] != 10'd3) : (lfsr_m[9:0] >= 10'd64))) begin
            @(negedge clk);
            waited++;
        end
        exp_delay      = RMIN + int'(lfsr_m[9:0]);
        countdown_done = 1'b1;
        @(negedge clk);
        countdown_done = 1'b0;
    endtask

    task automatic wait_go(input string tag, input int exp_delay,
                           input bit poke_arm, input bit release_btn);
        int cycles = 0;
        int limit  = TICK * exp_delay + 20;
        bit seen   = 1'b0;
        while (!seen && cycles < limit) begin
            if (poke_arm && cycles == 2)    countdown_done = 1'b1;
            if (poke_arm && cycles == 4)    countdown_done = 1'b0;
            if (release_btn && cycles == 2) btn = 1'b0;
            if (go_led === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
        countdown_done = 1'b0;
        check({tag, "_go_seen"}, seen, 1);
        check({tag, "_go_timing"},
              (cycles >= TICK * exp_delay - 1) && (cycles <= TICK * exp_delay + 1), 1);
        check({tag, "_busy_at_go"}, busy, 1);
    endtask

    // Called at the negedge where go_led was first seen high.
    task automatic press_after(input string tag, input int n);
        repeat (TICK * n) @(posedge clk);
        @(negedge clk);
        btn = 1'b1;
        sb_q.push_back('{result: to_bcd(n), valid: 1'b1, fs: 1'b0, to: 1'b0});
        @(negedge clk);
        check({tag, "_valid_latency"}, result_valid, 1);
        btn = 1'b0;
    endtask

    task automatic finish_round(input string tag, input int bound);
        int   waited = 0;
        exp_t e;
        while (busy === 1'b1 && waited < bound) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_in_time"}, busy, 0);
        @(negedge clk);
        check({tag, "_sb_entry"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_result"},      result_bcd,   e.result);
            check({tag, "_valid"},       result_valid, e.valid);
            check({tag, "_false_start"}, false_start,  e.fs);
            check({tag, "_timeout"},     timeout,      e.to);
            if (e.valid && !e.to && e.result < best_m) best_m = e.result;
        end
        check({tag, "_go_low"}, go_led, 0);
        check({tag, "_best"},   best_bcd, BEST_EN ? best_m : 16'h9999);
    endtask

    task automatic false_start_round(input string tag);
        int d;
        bit go_flag = 1'b0;
        arm_round(1'b0, d);
        repeat (TICK) begin
            @(negedge clk);
            if (go_led !== 1'b0) go_flag = 1'b1;
        end
        btn = 1'b1;
        sb_q.push_back('{result: 16'h0000, valid: 1'b0, fs: 1'b1, to: 1'b0});
        @(negedge clk);
        btn = 1'b0;
        check({tag, "_go_never"}, go_flag | go_led, 0);
        finish_round(tag, 100);
    endtask

    initial begin
        int          d;
        logic [15:0] plan_best [4];
        int          plan_ms   [4];

        plan_ms   = '{250, 120, -1, 300};
        plan_best = '{16'h0250, 16'h0120, 16'h0120, 16'h0120};

        rst            = 1'b1;
        countdown_done = 1'b0;
        btn            = 1'b0;
        best_m         = 16'h9999;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_check("post_reset", 20);

        // Normal round; an extra countdown_done edge mid-wait must be ignored.
        arm_round(1'b1, d);
        wait_go("round37", d, 1'b1, 1'b0);
        press_after("round37", 37);
        finish_round("round37", 100);

        false_start_round("false_start");

        // Button held through arming, released, then a genuine press.
        @(negedge clk);
        btn = 1'b1;
        repeat (3) @(negedge clk);
        arm_round(1'b0, d);
        wait_go("held_btn", d, 1'b0, 1'b1);
        press_after("held_btn", 12);
        finish_round("held_btn", 100);

        // No press at all.
        arm_round(1'b0, d);
        wait_go("timeout", d, 1'b0, 1'b0);
        sb_q.push_back('{result: 16'h9999, valid: 1'b1, fs: 1'b0, to: 1'b1});
        finish_round("timeout", 41000);

        // Asynchronous reset in the middle of MEASURE, away from any clock edge.
        arm_round(1'b0, d);
        wait_go("rst_mid", d, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst    = 1'b0;
        best_m = 16'h9999;
        idle_check("rst_mid", 20);
        check("sb_drained", sb_q.size(), 0);

        // Best-score sequence: 0250, 0120, false start, 0300.
        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("best%0d", i);
            if (plan_ms[i] < 0) begin
                false_start_round(tag);
            end else begin
                arm_round(1'b0, d);
                wait_go(tag, d, 1'b0, 1'b0);
                press_after(tag, plan_ms[i]);
                finish_round(tag, 100);
            end
            check({tag, "_best_plan"}, best_bcd, BEST_EN ? plan_best[i] : 16'h9999);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
